// File: rtl/reverb_m2s_fifo_v2.sv
// reverb_m2s_fifo_v2: Avalon-MM write to Avalon-ST source FWFT FIFO with status, flush and
// optional drop-on-full mode plus saturating drop counter (enabled by M2S_FIFO_DROP_CNT_EN).
module reverb_m2s_fifo_v2 #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4
) (
  input  logic              wrclock,
  input  logic              reset,
  input  logic [1:0]        avalonmm_write_slave_address,
  input  logic              avalonmm_write_slave_write,
  input  logic [31:0]       avalonmm_write_slave_writedata,
  input  logic              avalonmm_write_slave_read,
  output logic [31:0]       avalonmm_write_slave_readdata,
  output logic              avalonmm_write_slave_waitrequest,
  output logic [DATA_W-1:0] avalonst_source_data,
  output logic              avalonst_source_valid,
  input  logic              avalonst_source_ready,
  output logic              almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d, ram_cnt;
  logic [DATA_W-1:0] data_q, data_d;
  logic valid_q, valid_d, af_q, dm_q;
  logic [15:0] drop_q;
  logic full, empty, push_req, push, pop, flush, load, ram_rd, ram_wr;
  logic [1:0] addr;
  logic wr;
  assign addr = avalonmm_write_slave_address;
  assign wr = avalonmm_write_slave_write;
  always_comb begin
    full = level_q == LW'(DEPTH);
    empty = level_q == '0;
    push_req = wr & (addr == 2'd0);
    push = push_req & !full;
    pop = valid_q & avalonst_source_ready;
    flush = wr & (addr == 2'd2) & avalonmm_write_slave_writedata[0];
    ram_cnt = level_q - LW'(valid_q);
    load = pop | !valid_q;
    ram_rd = load & (ram_cnt != '0);
    // a push into an empty RAM while the output register refills bypasses the RAM
    ram_wr = push & !(load & (ram_cnt == '0));
    valid_d = flush ? 1'b0 : load ? (ram_rd | push) : valid_q;
    data_d = ram_rd ? mem[rd_ptr_q] : (load & push) ? avalonmm_write_slave_writedata[DATA_W-1:0] : data_q;
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(ram_rd);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(ram_wr);
    level_d = flush ? '0 : level_q + LW'(push) - LW'(pop);
    avalonmm_write_slave_waitrequest = reset | (push_req & full & !dm_q);
    avalonmm_write_slave_readdata = !avalonmm_write_slave_read ? 32'd0 :
      (addr == 2'd1) ? {12'd0, dm_q, af_q, full, empty, 5'd0, 11'(level_q)} :
      (addr == 2'd2) ? {30'd0, dm_q, 1'b0} :
      (addr == 2'd3) ? {16'd0, drop_q} : 32'd0;
  end
  always_ff @(posedge wrclock) if (ram_wr) mem[wr_ptr_q] <= avalonmm_write_slave_writedata[DATA_W-1:0];
  always_ff @(posedge wrclock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      af_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
      data_q <= data_d;
      valid_q <= valid_d;
      af_q <= level_q >= LW'(AF_LEVEL);
    end
  end
`ifdef M2S_FIFO_DROP_CNT_EN
  logic dm_d;
  logic [15:0] drop_d;
  always_comb begin
    dm_d = (wr & (addr == 2'd2)) ? avalonmm_write_slave_writedata[1] : dm_q;
    drop_d = (wr & (addr == 2'd3)) ? 16'd0 : (push_req & full & dm_q & (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end
  always_ff @(posedge wrclock) begin
    if (reset) begin
      dm_q <= 1'b0;
      drop_q <= '0;
    end else begin
      dm_q <= dm_d;
      drop_q <= drop_d;
    end
  end
`else
  assign dm_q = 1'b0;
  assign drop_q = '0;
`endif
  assign avalonst_source_data = data_q;
  assign avalonst_source_valid = valid_q;
  assign almost_full = af_q;
endmodule

// File: tb/tb_reverb_m2s_fifo_v2.sv
// tb_reverb_m2s_fifo_v2: randomized scoreboard bench for reverb_m2s_fifo_v2 (DEPTH=8, DATA_W=16).
module tb_reverb_m2s_fifo_v2;
  localparam int DW = 16;
  localparam int D = 8;
  localparam int AF = 4;
`ifdef M2S_FIFO_DROP_CNT_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, rd = 1'b0, sready = 1'b0;
  logic [1:0] addr = 2'd0;
  logic [31:0] wdata = 32'd0, rdata;
  logic waitreq, svalid, af;
  logic [DW-1:0] sdata;
  bit rand_rdy = 1'b0;
  int checks = 0, failures = 0;
  logic [DW-1:0] q[$];
  int m_level = 0, m_drop = 0;
  bit m_af = 1'b0, m_dm = 1'b0;

  always #5 clk = ~clk;

  reverb_m2s_fifo_v2 #(.DATA_W(DW), .DEPTH(D), .AF_LEVEL(AF)) dut (
    .wrclock(clk), .reset(rst),
    .avalonmm_write_slave_address(addr),
    .avalonmm_write_slave_write(wr),
    .avalonmm_write_slave_writedata(wdata),
    .avalonmm_write_slave_read(rd),
    .avalonmm_write_slave_readdata(rdata),
    .avalonmm_write_slave_waitrequest(waitreq),
    .avalonst_source_data(sdata),
    .avalonst_source_valid(svalid),
    .avalonst_source_ready(sready),
    .almost_full(af)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd();
    if (!rd) return 32'd0;
    case (addr)
      2'd1: return {12'd0, m_dm, m_af, m_level == D, m_level == 0, 5'd0, 11'(m_level)};
      2'd2: return {30'd0, m_dm, 1'b0};
      2'd3: return {16'd0, 16'(m_drop)};
      default: return 32'd0;
    endcase
  endfunction

  // reference model: FIFO contents as a queue, occupancy as a plain count
  always @(posedge clk) begin
    bit pop_ok, push_ok;
    if (rst) begin
      q.delete();
      m_level = 0; m_af = 0; m_dm = 0; m_drop = 0;
    end else begin
      pop_ok = (m_level > 0) && sready;
      push_ok = wr && addr == 2'd0 && m_level < D;
      m_af = m_level >= AF;
      if (wr && addr == 2'd0 && m_level == D && m_dm && m_drop < 65535) m_drop++;
      if (push_ok) q.push_back(wdata[DW-1:0]);
      m_level += int'(push_ok) - int'(pop_ok);
      if (wr && addr == 2'd2) begin
        m_dm = DROP_EN && wdata[1];
        if (wdata[0]) begin m_level = 0; q.delete(); end
      end
      if (wr && addr == 2'd3) m_drop = 0;
    end
  end

  // monitor: compares DUT outputs against the model away from the active edge
  always @(negedge clk) begin
    check("waitrequest", 32'(waitreq), 32'(rst || (wr && addr == 2'd0 && m_level == D && !m_dm)));
    check("valid", 32'(svalid), 32'(m_level > 0));
    check("almost_full", 32'(af), 32'(m_af));
    check("readdata", rdata, exp_rd());
    if (svalid && q.size() > 0) check("data", 32'(sdata), 32'(q[0]));
    if (svalid && sready) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL pop: beat %h with empty scoreboard at %0t", sdata, $time);
      end else void'(q.pop_front());
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) sready = 1'($urandom_range(0, 1));
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mm_wr(input logic [1:0] a, input logic [31:0] d);
    int n = 0;
    addr = a; wdata = d; wr = 1'b1;
    @(negedge clk);
    while (waitreq && n < 100) begin n++; @(negedge clk); end
    if (waitreq) begin
      checks++; failures++;
      $display("FAIL wr_timeout: waitrequest still %b after %0d cycles, required 0", waitreq, n);
    end
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic mm_rd(input logic [1:0] a);
    addr = a; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  initial begin
    idle(3);
    rst = 1'b0;
    check("reset_data", 32'(sdata), 32'd0);
    mm_rd(1); mm_rd(2); mm_rd(3);
    sready = 1'b1;
    mm_wr(0, 32'h1234);
    idle(3);
    mm_rd(1);
    sready = 1'b0;
    for (int i = 0; i < D; i++) mm_wr(0, 32'h100 + i);
    mm_rd(1);
    fork
      mm_wr(0, 32'h108);
      begin idle(5); sready = 1'b1; end
    join
    idle(12);
    for (int i = 0; i < 100; i++) mm_wr(0, $urandom);
    idle(3);
    mm_wr(2, 32'h2);
    sready = 1'b0;
    for (int i = 0; i < D; i++) mm_wr(0, 32'h200 + i);
    if (DROP_EN) for (int i = 0; i < 3; i++) mm_wr(0, 32'h300 + i);
    mm_rd(3); mm_rd(1);
    sready = 1'b1;
    idle(12);
    mm_wr(3, 32'h0);
    mm_rd(3);
    mm_wr(2, 32'h0);
    sready = 1'b0;
    for (int i = 0; i < 5; i++) mm_wr(0, 32'h400 + i);
    mm_rd(1);
    mm_wr(2, 32'h1);
    mm_rd(1);
    mm_wr(0, 32'hABC);
    sready = 1'b1;
    idle(3);
    sready = 1'b0;
    for (int i = 0; i < 3; i++) mm_wr(0, 32'h500 + i);
    sready = 1'b1;
    mm_wr(2, 32'h1);
    mm_rd(1);
    rand_rdy = 1'b1;
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 15);
      if (r < 8) mm_wr(0, $urandom);
      else if (r == 8) mm_wr(2, {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0)});
      else if (r == 9) mm_wr(3, $urandom);
      else if (r < 13) mm_rd(2'($urandom_range(0, 3)));
      else idle(1);
    end
    rand_rdy = 1'b0;
    sready = 1'b0;
    mm_wr(2, 32'h1);
    for (int i = 0; i < D; i++) mm_wr(0, 32'h600 + i);
    addr = 2'd0; wdata = 32'h6FF; wr = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(2);
    rst = 1'b0; wr = 1'b0;
    check("reset_stall_data", 32'(sdata), 32'd0);
    mm_rd(1); mm_rd(2); mm_rd(3);
    sready = 1'b1;
    mm_wr(0, 32'h77);
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
